// File: rtl/step_timer_unit.sv
// Purpose: signed step temp register with sign flags, plus prescaled inter-step delay FSM.
// Latency: temp updates one edge after an op; delay_done first high at cycle delay_value*PRESCALE+2 after start.
// Backpressure: enable_delay_counter low freezes a running delay; DONE is held until enable acknowledges it.
module step_timer_unit #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE   = 1000,
    parameter int PRESCALE_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_temp_register,
    input  logic              increment_temp_register,
    input  logic              decrement_temp_register,
    input  logic [DATA_W-1:0] step_count_in,
    input  logic              start_delay_counter,
    input  logic              enable_delay_counter,
    input  logic [DATA_W-1:0] delay_value,
    output logic [DATA_W-1:0] temp_value,
    output logic              temp_is_positive,
    output logic              temp_is_negative,
    output logic              temp_is_zero,
    output logic              delay_done,
    output logic              delay_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last prescaler value before a tick; PRESCALE=1 makes every enabled cycle a tick.
    localparam logic [PRESCALE_W-1:0] LP_PRESC_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [DATA_W-1:0]     r_temp;
    logic [DATA_W-1:0]     r_count;
    logic [PRESCALE_W-1:0] r_presc;
    state_t                r_state;
    logic                  r_done;
    logic                  r_busy;
    logic                  w_temp_zero;
    logic                  w_temp_neg;

    // Temp register: load beats inc/dec, inc+dec together hold, wrap on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_temp <= '0;
        end else if (load_temp_register) begin
            r_temp <= step_count_in;
        end else if (increment_temp_register && !decrement_temp_register) begin
            r_temp <= r_temp + 1'b1;
        end else if (decrement_temp_register && !increment_temp_register) begin
            r_temp <= r_temp - 1'b1;
        end
    end

    // Delay FSM with prescaler; done/busy are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_presc <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (start_delay_counter) begin
            // A restart from any state reloads the count and realigns the prescaler.
            r_state <= ST_RUN;
            r_count <= delay_value;
            r_presc <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (r_count == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (enable_delay_counter) begin
                        if (r_presc == LP_PRESC_LAST) begin
                            r_presc <= '0;
                            r_count <= r_count - 1'b1;
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // Hold done until the controller acknowledges with enable.
                    if (enable_delay_counter) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sign flags decoded from the temp register; exactly one is ever high.
    always_comb begin
        w_temp_zero = (r_temp == '0);
        w_temp_neg  = r_temp[DATA_W-1];
    end

    assign temp_value       = r_temp;
    assign temp_is_zero     = w_temp_zero;
    assign temp_is_negative = w_temp_neg;
    assign temp_is_positive = !w_temp_neg && !w_temp_zero;
    assign delay_done       = r_done;
    assign delay_busy       = r_busy;

endmodule

// File: tb/tb_step_timer_unit.sv
// Purpose: randomized and directed bench for step_timer_unit against a tick-count reference model.
// Latency: outputs compared #1 after every rising edge.
// Backpressure: enable is randomly dropped to exercise delay pauses.
module tb_step_timer_unit;

    localparam int DW = 8;
    localparam int P  = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_temp_register;
    logic          increment_temp_register;
    logic          decrement_temp_register;
    logic [DW-1:0] step_count_in;
    logic          start_delay_counter;
    logic          enable_delay_counter;
    logic [DW-1:0] delay_value;
    logic [DW-1:0] temp_value;
    logic          temp_is_positive;
    logic          temp_is_negative;
    logic          temp_is_zero;
    logic          delay_done;
    logic          delay_busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: temp as a wrapping integer, delay as remaining enabled run cycles.
    logic [DW-1:0] m_temp;
    int            m_mode;   // 0 idle, 1 running, 2 done
    int            m_rem;

    step_timer_unit #(.DATA_W(DW), .PRESCALE(P), .PRESCALE_W(PW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .load_temp_register      (load_temp_register),
        .increment_temp_register (increment_temp_register),
        .decrement_temp_register (decrement_temp_register),
        .step_count_in           (step_count_in),
        .start_delay_counter     (start_delay_counter),
        .enable_delay_counter    (enable_delay_counter),
        .delay_value             (delay_value),
        .temp_value              (temp_value),
        .temp_is_positive        (temp_is_positive),
        .temp_is_negative        (temp_is_negative),
        .temp_is_zero            (temp_is_zero),
        .delay_done              (delay_done),
        .delay_busy              (delay_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        reset                   = 1'b0;
        load_temp_register      = 1'b0;
        increment_temp_register = 1'b0;
        decrement_temp_register = 1'b0;
        step_count_in           = '0;
        start_delay_counter     = 1'b0;
        enable_delay_counter    = 1'b0;
        delay_value             = '0;
    endtask

    // Advance one edge: update the model from the inputs the DUT sampled, then compare.
    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            m_temp = '0;
            m_mode = 0;
            m_rem  = 0;
        end else begin
            if (load_temp_register)
                m_temp = step_count_in;
            else if (increment_temp_register && !decrement_temp_register)
                m_temp = DW'((int'(m_temp) + 1) % 256);
            else if (decrement_temp_register && !increment_temp_register)
                m_temp = DW'((int'(m_temp) + 255) % 256);

            if (start_delay_counter) begin
                m_mode = 1;
                m_rem  = int'(delay_value) * P;
            end else if (m_mode == 1) begin
                if (m_rem == 0) m_mode = 2;
                else if (enable_delay_counter) m_rem--;
            end else if (m_mode == 2) begin
                if (enable_delay_counter) m_mode = 0;
            end
        end
        #1;
        chk("temp_value", int'(temp_value), int'(m_temp));
        chk("positive", int'(temp_is_positive), int'($signed(m_temp) > 0));
        chk("negative", int'(temp_is_negative), int'($signed(m_temp) < 0));
        chk("zero", int'(temp_is_zero), int'(m_temp == 0));
        chk("delay_done", int'(delay_done), int'(m_mode == 2));
        chk("delay_busy", int'(delay_busy), int'(m_mode == 1));
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Start a delay of dv ticks at cycle 0, enable held except cycles [ps,pe]; check done only at cycle exp.
    task automatic run_delay(input int dv, input int ps, input int pe, input int exp, input string tag);
        idle_inputs();
        for (int c = 0; c <= exp + 1; c++) begin
            start_delay_counter  = (c == 0);
            delay_value          = DW'(dv);
            enable_delay_counter = (c >= 1) && !(c >= ps && c <= pe);
            cyc();
            chk(tag, int'(delay_done), int'(c + 1 == exp));
        end
        chk({tag, "_idle"}, int'(delay_busy), 0);
        idle_inputs();
    endtask

    initial begin
        m_temp = '0;
        m_mode = 0;
        m_rem  = 0;
        idle_inputs();
        do_reset();
        chk("rst_zero", int'(temp_is_zero), 1);
        chk("rst_busy", int'(delay_busy), 0);
        chk("rst_done", int'(delay_done), 0);

        // Load -3, then three increments back to zero.
        load_temp_register = 1'b1;
        step_count_in      = 8'hFD;
        cyc();
        chk("load_neg", int'(temp_is_negative), 1);
        load_temp_register      = 1'b0;
        increment_temp_register = 1'b1;
        repeat (3) cyc();
        chk("inc_to_zero", int'(temp_is_zero), 1);
        chk("inc_to_zero_val", int'(temp_value), 0);
        idle_inputs();

        // Wrap, load priority, and inc+dec hold.
        load_temp_register = 1'b1;
        step_count_in      = 8'd127;
        cyc();
        load_temp_register      = 1'b0;
        increment_temp_register = 1'b1;
        cyc();
        chk("wrap_val", int'(temp_value), 128);
        chk("wrap_neg", int'(temp_is_negative), 1);
        increment_temp_register = 1'b0;
        load_temp_register      = 1'b1;
        decrement_temp_register = 1'b1;
        step_count_in           = 8'd5;
        cyc();
        chk("load_wins", int'(temp_value), 5);
        load_temp_register      = 1'b0;
        increment_temp_register = 1'b1;
        cyc();
        chk("incdec_hold", int'(temp_value), 5);
        idle_inputs();

        // Delay timing: nominal, paused, zero length.
        run_delay(3, 0, -1, 14, "done_nominal");
        run_delay(3, 4, 8, 19, "done_paused");
        run_delay(0, 0, -1, 2, "done_zero");

        // Restart at cycle 6 reloads the delay.
        idle_inputs();
        for (int c = 0; c <= 21; c++) begin
            start_delay_counter  = (c == 0) || (c == 6);
            delay_value          = 8'd3;
            enable_delay_counter = (c >= 1);
            cyc();
            chk("done_restart", int'(delay_done), int'(c + 1 == 20));
        end
        idle_inputs();

        // Reset mid-run while count is 2, with a nonzero temp.
        load_temp_register = 1'b1;
        step_count_in      = 8'd9;
        cyc();
        idle_inputs();
        for (int c = 0; c < 6; c++) begin
            start_delay_counter  = (c == 0);
            delay_value          = 8'd3;
            enable_delay_counter = (c >= 1);
            cyc();
        end
        chk("pre_rst_busy", int'(delay_busy), 1);
        reset = 1'b1;
        cyc();
        chk("rst_run_busy", int'(delay_busy), 0);
        chk("rst_run_done", int'(delay_done), 0);
        chk("rst_run_zero", int'(temp_is_zero), 1);
        idle_inputs();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset                   = ($urandom_range(199) == 0);
            load_temp_register      = ($urandom_range(9) == 0);
            increment_temp_register = ($urandom_range(2) == 0);
            decrement_temp_register = ($urandom_range(2) == 0);
            step_count_in           = DW'($urandom_range(255));
            start_delay_counter     = ($urandom_range(24) == 0);
            delay_value             = DW'($urandom_range(4));
            enable_delay_counter    = ($urandom_range(4) != 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
